// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   // Width of a counter that must hold 0..cycles; never narrower than one bit.
   function automatic int filt_cnt_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: synchroniser, glitch filter, edge pulses, mode
// qualification, sticky pending flag and saturating event counter.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic             level_o,
   output logic             rising_edge_o,
   output logic             falling_edge_o,
   output logic             event_o,
   output logic             pending_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int               FCW       = filt_cnt_w(FILTER_CYCLES);
   localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILTER_CYCLES - 1);
   localparam logic [FCW-1:0]   FILT_ONE  = FCW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   event_q, event_d;
   logic                   pending_q, pending_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   sync_lvl_s;
   logic                   accept_s;
   edge_mode_e             mode_s;

   // Next-state logic for the whole channel.
   always_comb begin
      sync_d    = '0;
      sync_d[0] = a_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end

      sync_lvl_s = sync_q[SYNC_STAGES-1];
      // A differing level is accepted on the edge its run reaches FILTER_CYCLES.
      accept_s   = (sync_lvl_s != level_q) && (filt_cnt_q == FILT_LAST);

      if (sync_lvl_s == level_q) begin
         filt_cnt_d = '0;
      end else if (accept_s) begin
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + FILT_ONE;
      end

      level_d = accept_s ? sync_lvl_s : level_q;
      rise_d  = accept_s & sync_lvl_s;
      fall_d  = accept_s & ~sync_lvl_s;

      mode_s = edge_mode_e'(mode_i);
      case (mode_s)
         EDGE_OFF:  event_d = 1'b0;
         EDGE_RISE: event_d = rise_d;
         EDGE_FALL: event_d = fall_d;
         EDGE_BOTH: event_d = rise_d | fall_d;
         default:   event_d = 1'b0;
      endcase

      if (event_d) begin
         pending_d = 1'b1;
      end else if (clr_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      // A clear that collides with an event leaves that event counted.
      if (clr_i) begin
         count_d = event_d ? CNT_ONE : '0;
      end else if (event_d && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         filt_cnt_q <= '0;
         level_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         event_q    <= 1'b0;
         pending_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         sync_q     <= sync_d;
         filt_cnt_q <= filt_cnt_d;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         event_q    <= event_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
      end
   end

   assign level_o        = level_q;
   assign rising_edge_o  = rise_q;
   assign falling_edge_o = fall_q;
   assign event_o        = event_q;
   assign pending_o      = pending_q;
   assign count_o        = count_q;

endmodule

// File: rtl/multi_edge_detector.sv
// NUM_CH independent edge detector channels with a combined interrupt request.
module multi_edge_detector
   import edge_det_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       a_i,
   input  logic [2*NUM_CH-1:0]     mode_i,
   input  logic [NUM_CH-1:0]       clr_i,
   output logic [NUM_CH-1:0]       level_o,
   output logic [NUM_CH-1:0]       rising_edge_o,
   output logic [NUM_CH-1:0]       falling_edge_o,
   output logic [NUM_CH-1:0]       event_o,
   output logic [NUM_CH-1:0]       pending_o,
   output logic [NUM_CH*CNT_W-1:0] count_o,
   output logic                    irq_o
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_det_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .a_i           (a_i[i]),
         .mode_i        (mode_i[2*i +: 2]),
         .clr_i         (clr_i[i]),
         .level_o       (level_o[i]),
         .rising_edge_o (rising_edge_o[i]),
         .falling_edge_o(falling_edge_o[i]),
         .event_o       (event_o[i]),
         .pending_o     (pending_o[i]),
         .count_o       (count_o[CNT_W*i +: CNT_W])
      );
   end

   // Interrupt follows the pending flops directly.
   assign irq_o = |pending_o;

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised multi-channel edge detector that extends the single-bit rising/falling detector.
- Each channel adds an input synchroniser, a glitch filter, per-channel edge-mode selection, a sticky pending flag and a saturating event counter.
- The block sits between asynchronous external inputs (buttons, status lines) and a register/interrupt block; the pending and counter outputs feed an interrupt request.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (1..4).
- FILTER_CYCLES, 1: consecutive cycles a new synchronised level must persist before it is accepted (>=1; 1 means no filtering).
- CNT_W, 8: width of each per-channel event counter (>=1).

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-high reset.
- a_i, input, NUM_CH: raw asynchronous inputs, bit i is channel i.
- mode_i, input, 2*NUM_CH: per-channel mode, bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- clr_i, input, NUM_CH: per-channel synchronous clear of pending flag and counter.
- level_o, output, NUM_CH: filtered level per channel.
- rising_edge_o, output, NUM_CH: one-cycle pulse on each filtered 0->1 transition, independent of mode.
- falling_edge_o, output, NUM_CH: one-cycle pulse on each filtered 1->0 transition, independent of mode.
- event_o, output, NUM_CH: one-cycle pulse on each transition that the current mode enables.
- pending_o, output, NUM_CH: sticky flag, set by event, cleared by clr_i.
- count_o, output, NUM_CH*CNT_W: saturating event count, bits [CNT_W*(i+1)-1 : CNT_W*i].
- irq_o, output, 1: OR of pending_o.

Behaviour:
- Clock and reset: clk with asynchronous active-high reset. While reset is high, all flops clear to 0: synchroniser, filtered level, filter counters, edge pulses, pending, counts. All outputs are therefore 0 during and immediately after reset.
- Synchroniser: SYNC_STAGES-deep flop chain per channel. Its last stage is the sync level s[i].
- Filter:
  - Per-channel counter of width $clog2(FILTER_CYCLES+1), plus filtered level f[i].
  - At each clk edge where s==f, the counter clears to 0.
  - At each edge where s!=f and counter==FILTER_CYCLES-1: f<=s and counter<=0.
  - At any other edge where s!=f, the counter increments.
  - A pulse on s shorter than FILTER_CYCLES cycles never changes f and generates no pulse.
- Edge detection:
  - Edge pulses are registered and assert in the same edge that f updates, so they coincide with the level_o change.
  - rising_edge_o[i] = 1 for exactly one cycle when f goes 0->1; falling_edge_o[i] likewise for 1->0.
- Latency: if a_i changes and is first sampled at edge 0 and then held stable, level_o and the edge pulse change at edge SYNC_STAGES+FILTER_CYCLES-1. Example: S=2, F=1 gives edge 2.
- Mode qualification:
  - event_o = (rise & mode[0]) | (fall & mode[1]), registered alongside the edge pulses.
  - The mode is sampled at the edge of the transition. A mode change never creates or cancels events retroactively.
- Pending:
  - An event sets pending at the same edge event_o asserts. pending then stays 1 until clr_i[i] is high at a clk edge.
  - Simultaneous event and clr_i: pending = 1 (set wins).
- Counter:
  - Increments by 1 per event and saturates at 2^CNT_W-1 with no wrap.
  - clr_i clears it to 0.
  - Simultaneous event and clr_i: count = 1.
- irq_o is the combinational OR of the pending flops (no extra latency).
- Independence: channels are fully independent. Simultaneous events on all channels are all captured.
- Reset mid-operation: any in-flight filter count or pulse is discarded. After release, a channel whose input is held at 1 yields exactly one rising edge, with the normal latency.

Decomposition:
- Package edge_det_pkg:
  - enum edge_mode_e {EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11}.
  - Localparam-derived filter counter width helper.
- Sub-module edge_det_channel (one channel: sync, filter, edge, pending, counter) with the same parameters minus NUM_CH.
- Top level multi_edge_detector instantiates NUM_CH channels in a generate loop, slices the buses and ORs pending into irq_o.

Test Plan:
- Reset/latency: NUM_CH=4, S=2, F=1, mode ch0=01. Release reset, drive a_i[0] 0->1 sampled at edge 0 -> level_o[0], rising_edge_o[0] and event_o[0] high only in the cycle after edge 2. pending_o[0]=1, count_o[0]=1, irq_o=1.
- Glitch filter: F=4. Hold a_i[1] high for 3 cycles, then low -> no edge, level_o[1] stays 0. Hold high for 4 cycles -> rising pulse at edge S+3 after first sample.
- Modes: ch2 mode=10, ch3 mode=11. Toggle both inputs 0->1->0 -> ch2 gets event_o only on the fall, count=1. ch3 gets two events, count=2. rising/falling pulses appear on both channels regardless of mode.
- Clear and set collision: assert clr_i[3] in the same cycle as a ch3 event with count=5 -> next cycle pending_o[3]=1 and count_o[3]=1. clr_i alone -> pending=0, count=0, irq_o drops if no other channel is pending.
- Saturation: CNT_W=2, mode=11. Apply 5 transitions -> count_o sequence 1, 2, 3, 3, 3 with no wrap.
- Reset mid-filter: F=8. Assert reset when the filter count is 5, then release with the input held at 1 -> exactly one rising pulse at edge S+7 after release, and no pulse generated from the pre-reset count.
